// File: rtl/fpga_cfg_loader.sv
// Wishbone-mapped configuration engine: buffers bitstream words in a FIFO and
// serialises them into NUM_CHAINS parallel ccff chains at a programmable rate.
module fpga_cfg_loader #(
    parameter int unsigned NUM_CHAINS = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  prog_clk,
    output logic                  prog_reset,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  irq
);
    localparam int unsigned SLICES  = 32 / NUM_CHAINS;
    localparam int unsigned SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETUP, ST_HIGH, ST_DONE} state_t;

    state_t               state;
    logic [31:0]          len_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [31:0]          tail_reg;
    logic [31:0]          remaining;
    logic [31:0]          sreg;
    logic [SLICE_W-1:0]   slice;
    logic [DIV_W-1:0]     cnt;
    logic                 ie;
    logic                 done;
    logic                 ovf;
    logic [31:0]          mem [FIFO_DEPTH];
    logic [LVL_W-1:0]     wr_ptr;
    logic [LVL_W-1:0]     rd_ptr;

    logic                 req, wr;
    logic [2:0]           addr;
    logic                 start, abort, push, pop;
    logic [LVL_W-1:0]     level;
    logic                 full, empty, busy;
    logic [31:0]          fifo_rd, status, rdata;
    logic                 done_nxt, ovf_nxt, ie_nxt;
    logic                 unused_ok;

    // Bus decode: a new request is a strobe not already being acknowledged
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr        = req & wbs_we_i;
    assign addr      = wbs_adr_i[4:2];
    assign abort     = wr && (addr == 3'd0) && wbs_dat_i[2];
    assign start     = wr && (addr == 3'd0) && wbs_dat_i[0] && !wbs_dat_i[2];
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign empty     = (level == '0);
    assign busy      = (state != ST_IDLE);
    assign push      = wr && (addr == 3'd2) && !full;
    assign pop       = (state == ST_LOAD) && !empty;
    assign fifo_rd   = mem[rd_ptr[PTR_W-1:0]];
    assign status    = {16'h0, 8'(level), 3'b000, ovf, done, empty, full, busy};
    assign unused_ok = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i};

    // Read mux and next values of the sticky flags feeding irq
    always_comb begin
        rdata    = '0;
        done_nxt = done;
        ovf_nxt  = ovf;
        ie_nxt   = ie;
        case (addr)
            3'd0:    rdata = {28'h0, ie, 1'b0, prog_reset, 1'b0};
            3'd1:    rdata = status;
            3'd3:    rdata = len_reg;
            3'd4:    rdata = 32'(div_reg);
            3'd5:    rdata = tail_reg;
            default: rdata = '0;
        endcase
        if (wr && addr == 3'd0) ie_nxt = wbs_dat_i[3];
        if (wr && addr == 3'd1 && wbs_dat_i[3]) done_nxt = 1'b0;
        if (wr && addr == 3'd1 && wbs_dat_i[4]) ovf_nxt = 1'b0;
        if (wr && addr == 3'd2 && full) ovf_nxt = 1'b1;
        if (start && state == ST_IDLE) done_nxt = (len_reg == '0);
        if (state == ST_DONE && !abort) done_nxt = 1'b1;
    end

    // Wishbone ack/data and configuration registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            len_reg    <= '0;
            div_reg    <= '0;
            prog_reset <= 1'b0;
            ie         <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            if (wr && addr == 3'd0) prog_reset <= wbs_dat_i[1];
            if (wr && addr == 3'd3) len_reg <= wbs_dat_i;
            if (wr && addr == 3'd4) div_reg <= wbs_dat_i[DIV_W-1:0];
            ie   <= ie_nxt;
            done <= done_nxt;
            ovf  <= ovf_nxt;
            irq  <= ie_nxt & (done_nxt | ovf_nxt);
        end
    end

    // FIFO storage; writes only while not full
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= wbs_dat_i;
    end

    // FIFO pointers; abort flushes
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Shift engine: one SETUP/HIGH pair per shift cycle, LOAD between words
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            prog_clk  <= 1'b0;
            ccff_head <= '0;
            tail_reg  <= '0;
            remaining <= '0;
            sreg      <= '0;
            slice     <= '0;
            cnt       <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            prog_clk <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && len_reg != '0) begin
                        remaining <= len_reg;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    prog_clk <= 1'b0;
                    if (!empty) begin
                        ccff_head <= fifo_rd[NUM_CHAINS-1:0];
                        sreg      <= fifo_rd >> NUM_CHAINS;
                        slice     <= '0;
                        cnt       <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == div_reg) begin
                        cnt      <= '0;
                        prog_clk <= 1'b1;
                        tail_reg <= 32'({tail_reg, ccff_tail});
                        state    <= ST_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt == div_reg) begin
                        cnt       <= '0;
                        prog_clk  <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == 32'd1) begin
                            state <= ST_DONE;
                        end else if (slice == SLICE_W'(SLICES - 1)) begin
                            state <= ST_LOAD;
                        end else begin
                            slice     <= slice + 1'b1;
                            ccff_head <= sreg[NUM_CHAINS-1:0];
                            sreg      <= sreg >> NUM_CHAINS;
                            state     <= ST_SETUP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    prog_clk <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with a word-queue model of the shift stream.
module tb_fpga_cfg_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, dat_i = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        pc, preset, irq;
    logic [3:0]  head;
    logic [3:0]  tail_in = 4'h0;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_fifo[$];
    logic [31:0] m_cur = '0, m_tail = '0, m_len = '0;
    int          m_div = 0, m_rem = 0, m_slice = 0, m_pulses = 0;
    logic        m_done = 0, m_ovf = 0, m_ie = 0, m_preset = 0, m_skip = 0;
    logic [7:0]  obs_c0 = '0;
    logic        prev_pc = 0, prev_ack = 0;
    int          hi_len = 0, lo_len = 0;
    logic [31:0] rd;

    fpga_cfg_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .prog_clk(pc), .prog_reset(preset), .ccff_head(head), .ccff_tail(tail_in),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: bus hygiene, prog_clk timing, head bits vs the word queue
    always @(negedge clk) begin
        logic [3:0] exp_h;
        if (rst) begin
            prev_pc = 0; prev_ack = 0; hi_len = 0; lo_len = 0;
        end else begin
            chk("ack_single", 32'(ack & prev_ack), 32'd0);
            if (!ack) chk("dat_idle", dat_o, 32'd0);
            if (pc && !prev_pc) begin
                m_pulses++;
                if (m_rem <= 0) begin
                    chk("stray_pulse", 32'd1, 32'd0);
                end else begin
                    if (m_slice == 0) begin
                        if (m_fifo.size() == 0) chk("pulse_has_word", 32'd0, 32'd1);
                        else m_cur = m_fifo.pop_front();
                    end else begin
                        chk("low_len", 32'(lo_len), 32'(m_div + 1));
                    end
                    exp_h = 4'(m_cur >> (m_slice * 4));
                    chk("ccff_head", 32'(head), 32'(exp_h));
                    obs_c0 = {head[0], obs_c0[7:1]};
                    m_tail = {m_tail[27:0], tail_in};
                    m_slice = (m_slice + 1) % 8;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_slice = 0;
                        m_done = 1;
                    end
                end
            end
            if (!pc && prev_pc) begin
                if (!m_skip) chk("high_len", 32'(hi_len), 32'(m_div + 1));
                m_skip = 0;
            end
            if (pc) hi_len = prev_pc ? hi_len + 1 : 1;
            else    lo_len = prev_pc ? 1 : lo_len + 1;
            prev_pc  = pc;
            prev_ack = ack;
        end
    end

    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        int n;
        int acks;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = {27'b0, a, 2'b00}; dat_i = d;
        n = 0; acks = 0;
        @(posedge clk); #1; n++;
        while (!ack && n < 16) begin
            @(posedge clk); #1; n++;
        end
        if (ack) acks++;
        q = dat_o;
        stb = 0; cyc = 0; we = 0;
        @(posedge clk); #1;
        if (ack) acks++;
        chk("ack_count", 32'(acks), 32'd1);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, q);
    endtask

    function automatic logic [31:0] ctrl_word(input logic st, input logic ab);
        return {28'b0, m_ie, ab, m_preset, st};
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_fifo.size()) << 8;
        s[4] = m_ovf; s[3] = m_done;
        s[2] = (m_fifo.size() == 0); s[1] = (m_fifo.size() == 8);
        return s;
    endfunction

    task automatic push(input logic [31:0] w);
        if (m_fifo.size() >= 8) m_ovf = 1;
        else m_fifo.push_back(w);
        wb_write(3'd2, w);
    endtask

    task automatic set_len(input logic [31:0] v);
        m_len = v; wb_write(3'd3, v);
    endtask

    task automatic set_div(input int v);
        m_div = v; wb_write(3'd4, 32'(v));
    endtask

    task automatic start_run();
        m_pulses = 0; obs_c0 = '0; m_skip = 0; m_slice = 0;
        m_rem = int'(m_len);
        m_done = (m_len == 0);
        wb_write(3'd0, ctrl_word(1'b1, 1'b0));
    endtask

    task automatic do_abort();
        m_rem = 0; m_slice = 0; m_skip = 1;
        m_fifo.delete();
        wb_write(3'd0, ctrl_word(1'b0, 1'b1));
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        n = 0;
        s = 32'd1;
        while (s[0] && n < 200) begin
            wb_read(3'd1, s);
            n++;
        end
        chk("idle_timeout", 32'(s[0]), 32'd0);
    endtask

    task automatic wait_pulses(input int p);
        int n;
        n = 0;
        while (m_pulses < p && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("pulse_timeout", 32'(m_pulses >= p), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset values
        #12;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_pclk", 32'(pc), 32'd0);
        chk("rst_head", 32'(head), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk); rst = 0;

        // register access
        set_len(32'h40);
        set_div(3);
        wb_read(3'd3, rd); chk("len_rb", rd, 32'h40);
        wb_read(3'd4, rd); chk("div_rb", rd, 32'h3);
        wb_read(3'd1, rd); chk("status_reset", rd, 32'h4);
        wb_read(3'd0, rd); chk("ctrl_rb", rd, 32'h0);
        wb_read(3'd2, rd); chk("data_rd_zero", rd, 32'h0);
        wb_read(3'd6, rd); chk("adr6_zero", rd, 32'h0);

        // start with LEN=0 sets done immediately
        set_len(32'd0);
        start_run();
        wb_read(3'd1, rd); chk("len0_status", rd, 32'h0C);
        wb_write(3'd1, 32'h8); m_done = 0;

        // basic shift, DIV=0, LEN=8
        set_div(0);
        set_len(32'd8);
        push(32'h0000_00F1);
        push(32'h0000_000E);
        start_run();
        wait_idle();
        chk("basic_pulses", 32'(m_pulses), 32'd8);
        chk("basic_chain0", 32'(obs_c0), 32'h03);
        wb_read(3'd1, rd);
        chk("basic_status", rd, 32'h108);
        chk("basic_status_m", rd, model_status());
        wb_write(3'd1, 32'h8); m_done = 0;
        do_abort();
        wb_read(3'd1, rd); chk("flushed", rd, 32'h4);

        // underrun stall, plus a start while busy that must be ignored
        set_div(1);
        set_len(32'd16);
        push(32'hA5A5_1234);
        start_run();
        wait_pulses(8);
        repeat (20) @(posedge clk);
        #1 chk("stall_pclk", 32'(pc), 32'd0);
        wb_read(3'd1, rd); chk("stall_status", rd, 32'h5);
        wb_write(3'd0, ctrl_word(1'b1, 1'b0));
        push(32'h0F0F_00FF);
        wait_idle();
        chk("underrun_pulses", 32'(m_pulses), 32'd16);
        wb_read(3'd1, rd); chk("underrun_status", rd, model_status());
        chk("irq_masked", 32'(irq), 32'd0);
        wb_write(3'd1, 32'h8); m_done = 0;

        // overflow
        m_ie = 1;
        wb_write(3'd0, ctrl_word(1'b0, 1'b0));
        for (int i = 0; i < 9; i++) push(32'h100 + 32'(i));
        wb_read(3'd1, rd); chk("ovf_status", rd, 32'h812);
        chk("ovf_status_m", rd, model_status());
        chk("ovf_irq", 32'(irq), 32'd1);
        wb_write(3'd1, 32'h10); m_ovf = 0;
        @(posedge clk); #1 chk("ovf_irq_clr", 32'(irq), 32'd0);
        do_abort();

        // tail readback
        tail_in = 4'b0101;
        set_div(0);
        set_len(32'd8);
        push(32'h1234_5678);
        start_run();
        wait_idle();
        wb_read(3'd5, rd);
        chk("tail_rb", rd, 32'h5555_5555);
        chk("tail_rb_m", rd, m_tail);
        chk("done_irq", 32'(irq), 32'd1);
        wb_write(3'd1, 32'h8); m_done = 0;
        @(posedge clk); #1 chk("done_irq_clr", 32'(irq), 32'd0);
        tail_in = 4'h0;

        // abort mid-shift after 3 pulses
        m_ie = 0;
        set_div(2);
        set_len(32'd32);
        for (int i = 0; i < 4; i++) push(32'h3C3C_0000 ^ (32'h1111 * 32'(i)));
        start_run();
        wait_pulses(3);
        do_abort();
        chk("abort_pclk", 32'(pc), 32'd0);
        wb_read(3'd1, rd); chk("abort_status", rd, 32'h4);
        repeat (10) @(posedge clk);
        chk("abort_pulses", 32'(m_pulses), 32'd3);

        // asynchronous reset mid-shift
        m_preset = 1;
        set_div(3);
        set_len(32'd8);
        push(32'hFFFF_FFFF);
        start_run();
        wait_pulses(2);
        chk("pre_rst_preset", 32'(preset), 32'd1);
        chk("pre_rst_head", 32'(head), 32'hF);
        @(negedge clk); #2;
        rst = 1;
        #1;
        chk("arst_pclk", 32'(pc), 32'd0);
        chk("arst_head", 32'(head), 32'd0);
        chk("arst_preset", 32'(preset), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        m_rem = 0; m_slice = 0; m_skip = 0; m_fifo.delete();
        m_preset = 0; m_ie = 0; m_done = 0; m_len = '0; m_div = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        wb_read(3'd1, rd); chk("post_rst_status", rd, 32'h4);
        wb_read(3'd3, rd); chk("post_rst_len", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
